// File: rtl/wb_pkg.sv
// Shared register-bus definitions: widths, controller state codes and the
// SEL/address legality rule that initiator and slaves must agree on.
package wb_pkg;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_SW-1:0] sel;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

    // Register slaves only decode full words and naturally aligned halfwords.
    function automatic logic sel_legal(input logic [WB_SW-1:0] sel, input logic [1:0] adr_lo);
        case (sel)
            4'b1111:          sel_legal = (adr_lo == 2'b00);
            4'b1100, 4'b0011: sel_legal = ~adr_lo[0];
            default:          sel_legal = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles while a transaction is open and
// flags the last allowed cycle. A limit of 0 never expires.
module wb_timeout_cnt (
    input  logic        CLK,
    input  logic        RST_SYNC,
    input  logic        en,
    input  logic        clear,
    input  logic        active,
    input  logic [15:0] limit,
    output logic        expired
);
    logic [15:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            cnt <= '0;
        end else if (en) begin
            if (clear)
                cnt <= '0;
            else if (active)
                cnt <= cnt + 16'd1;
        end
    end

    assign expired = (limit != 16'd0) && (cnt == limit - 16'd1);
endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 pipelined initiator: one bus cycle per core request, with
// local SEL legality check, STALL/ACK/ERR handling and a timeout abort.
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit CHECK_SEL      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_SYNC,
    input  logic             EN,
    input  logic             REQ_IN,
    input  logic             REQ_WE_IN,
    input  logic [WB_AW-1:0] REQ_ADDR_IN,
    input  logic [WB_SW-1:0] REQ_SEL_IN,
    input  logic [WB_DW-1:0] REQ_WR_DATA_IN,
    output logic             REQ_ACK_OUT,
    output logic             RSP_VALID_OUT,
    output logic             RSP_ERR_OUT,
    output logic             RSP_TIMEOUT_OUT,
    output logic [WB_DW-1:0] RSP_RD_DATA_OUT,
    output logic [WB_AW-1:0] WB_ADR_OUT,
    output logic             WB_CYC_OUT,
    output logic             WB_STB_OUT,
    output logic             WB_WE_OUT,
    output logic [WB_SW-1:0] WB_SEL_OUT,
    output logic [WB_DW-1:0] WB_DAT_WR_OUT,
    input  logic [WB_DW-1:0] WB_DAT_RD_IN,
    input  logic             WB_ACK_IN,
    input  logic             WB_STALL_IN,
    input  logic             WB_ERR_IN
);
    logic [1:0] state;
    wb_req_t    req_q;
    logic       req_legal;
    logic       expired;

    assign REQ_ACK_OUT = EN & (state == ST_IDLE) & REQ_IN;
    assign req_legal   = !CHECK_SEL || sel_legal(REQ_SEL_IN, REQ_ADDR_IN[1:0]);

    assign WB_ADR_OUT    = req_q.adr;
    assign WB_WE_OUT     = req_q.we;
    assign WB_SEL_OUT    = req_q.sel;
    assign WB_DAT_WR_OUT = req_q.dat;

    wb_timeout_cnt u_tmo (
        .CLK      (CLK),
        .RST_SYNC (RST_SYNC),
        .en       (EN),
        .clear    (REQ_ACK_OUT),
        .active   (state != ST_IDLE),
        .limit    (16'(TIMEOUT_CYCLES)),
        .expired  (expired)
    );

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state           <= ST_IDLE;
            req_q           <= '0;
            WB_CYC_OUT      <= 1'b0;
            WB_STB_OUT      <= 1'b0;
            RSP_VALID_OUT   <= 1'b0;
            RSP_ERR_OUT     <= 1'b0;
            RSP_TIMEOUT_OUT <= 1'b0;
            RSP_RD_DATA_OUT <= '0;
        end else if (EN) begin
            RSP_VALID_OUT   <= 1'b0;
            RSP_ERR_OUT     <= 1'b0;
            RSP_TIMEOUT_OUT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_ACK_OUT) begin
                        req_q <= '{we: REQ_WE_IN, adr: REQ_ADDR_IN, sel: REQ_SEL_IN, dat: REQ_WR_DATA_IN};
                        if (req_legal) begin
                            state      <= ST_ADDR;
                            WB_CYC_OUT <= 1'b1;
                            WB_STB_OUT <= 1'b1;
                        end else begin
                            RSP_VALID_OUT <= 1'b1;
                            RSP_ERR_OUT   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    // ACK/ERR cannot legally arrive before the address phase is taken.
                    if (expired) begin
                        state           <= ST_IDLE;
                        WB_CYC_OUT      <= 1'b0;
                        WB_STB_OUT      <= 1'b0;
                        RSP_VALID_OUT   <= 1'b1;
                        RSP_ERR_OUT     <= 1'b1;
                        RSP_TIMEOUT_OUT <= 1'b1;
                    end else if (!WB_STALL_IN) begin
                        state      <= ST_DATA;
                        WB_STB_OUT <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (WB_ERR_IN || WB_ACK_IN) begin
                        state         <= ST_IDLE;
                        WB_CYC_OUT    <= 1'b0;
                        RSP_VALID_OUT <= 1'b1;
                        RSP_ERR_OUT   <= WB_ERR_IN;
                        if (!WB_ERR_IN && !req_q.we)
                            RSP_RD_DATA_OUT <= WB_DAT_RD_IN;
                    end else if (expired) begin
                        state           <= ST_IDLE;
                        WB_CYC_OUT      <= 1'b0;
                        RSP_VALID_OUT   <= 1'b1;
                        RSP_ERR_OUT     <= 1'b1;
                        RSP_TIMEOUT_OUT <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    WB_CYC_OUT <= 1'b0;
                    WB_STB_OUT <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: transaction-level timeline model,
// scripted slave, directed literal checks and a randomized run.
module tb_wb_master_ctrl;
    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST_SYNC, EN, REQ_IN, REQ_WE_IN;
    logic [31:0] REQ_ADDR_IN, REQ_WR_DATA_IN;
    logic [3:0]  REQ_SEL_IN;
    logic        REQ_ACK_OUT, RSP_VALID_OUT, RSP_ERR_OUT, RSP_TIMEOUT_OUT;
    logic [31:0] RSP_RD_DATA_OUT, WB_ADR_OUT, WB_DAT_WR_OUT;
    logic        WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT;
    logic [3:0]  WB_SEL_OUT;
    logic [31:0] WB_DAT_RD_IN = '0;
    logic        WB_ACK_IN = 1'b0, WB_STALL_IN = 1'b0, WB_ERR_IN = 1'b0;

    int n_tests = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    wb_master_ctrl #(.TIMEOUT_CYCLES(TMO), .CHECK_SEL(1'b1)) dut (
        .CLK(CLK), .RST_SYNC(RST_SYNC), .EN(EN),
        .REQ_IN(REQ_IN), .REQ_WE_IN(REQ_WE_IN), .REQ_ADDR_IN(REQ_ADDR_IN),
        .REQ_SEL_IN(REQ_SEL_IN), .REQ_WR_DATA_IN(REQ_WR_DATA_IN), .REQ_ACK_OUT(REQ_ACK_OUT),
        .RSP_VALID_OUT(RSP_VALID_OUT), .RSP_ERR_OUT(RSP_ERR_OUT),
        .RSP_TIMEOUT_OUT(RSP_TIMEOUT_OUT), .RSP_RD_DATA_OUT(RSP_RD_DATA_OUT),
        .WB_ADR_OUT(WB_ADR_OUT), .WB_CYC_OUT(WB_CYC_OUT), .WB_STB_OUT(WB_STB_OUT),
        .WB_WE_OUT(WB_WE_OUT), .WB_SEL_OUT(WB_SEL_OUT), .WB_DAT_WR_OUT(WB_DAT_WR_OUT),
        .WB_DAT_RD_IN(WB_DAT_RD_IN), .WB_ACK_IN(WB_ACK_IN),
        .WB_STALL_IN(WB_STALL_IN), .WB_ERR_IN(WB_ERR_IN)
    );

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;
    // Request plus the slave's script for it: s stall cycles, w idle DATA
    // cycles before the response of the given kind.
    typedef struct {
        logic        we;
        logic [31:0] addr, wdat, rdat;
        logic [3:0]  sel;
        int          s, w;
        kind_e       kind;
    } txn_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic bit legal(input logic [3:0] s, input logic [31:0] a);
        return (s == 4'hF && a[1:0] == 2'b00) || ((s == 4'hC || s == 4'h3) && !a[0]);
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] sel, input int s, input int w,
                                input kind_e k, input logic [31:0] rd);
        txn_t t;
        t.we = we; t.addr = a; t.wdat = d; t.sel = sel;
        t.s = s; t.w = w; t.kind = k; t.rdat = rd;
        return t;
    endfunction

    // Model: rel counts enabled edges since acceptance; the whole transaction
    // timeline (fin = last CYC cycle, response at fin+1) is fixed at acceptance.
    txn_t        nxt, cur, p_req;
    bit          active = 1'b0, ill, m_err, m_to;
    int          rel, fin, k;
    logic [31:0] exp_rd = '0;
    bit          p_rst = 1'b1, p_en = 1'b0, p_acc = 1'b0;
    bit          e_cyc, e_stb, e_rsp, e_idle, e_ack;

    task automatic start_txn(input txn_t t);
        cur = t; active = 1'b1; rel = 1;
        ill = !legal(t.sel, t.addr);
        if (ill) begin
            fin = 0; m_err = 1'b1; m_to = 1'b0;
        end else begin
            k = 2 + t.s + t.w;
            m_to  = (t.kind == K_NONE) || (k > TMO);
            fin   = m_to ? TMO : k;
            m_err = m_to || t.kind == K_ERR || t.kind == K_BOTH;
        end
    endtask

    always @(negedge CLK) begin
        if (p_rst) begin
            active = 1'b0; exp_rd = '0;
        end else if (p_en) begin
            if (active) begin
                rel++;
                if (rel == fin + 1 && !cur.we && !m_err) exp_rd = cur.rdat;
            end
            if (p_acc) start_txn(p_req);
        end
        e_cyc  = active && !ill && rel >= 1 && rel <= fin;
        e_stb  = e_cyc && rel <= cur.s + 1;
        e_rsp  = active && rel == fin + 1;
        e_idle = !active || rel >= fin + 1;
        e_ack  = EN && REQ_IN && e_idle;
        chk1("cyc", WB_CYC_OUT, e_cyc);
        chk1("stb", WB_STB_OUT, e_stb);
        chk1("rsp_valid", RSP_VALID_OUT, e_rsp);
        chk1("rsp_err", RSP_ERR_OUT, e_rsp && m_err);
        chk1("rsp_timeout", RSP_TIMEOUT_OUT, e_rsp && m_to);
        chk("rd_data", RSP_RD_DATA_OUT, exp_rd);
        chk1("req_ack", REQ_ACK_OUT, e_ack);
        if (e_cyc) begin
            chk("adr", WB_ADR_OUT, cur.addr);
            chk1("we", WB_WE_OUT, cur.we);
            chk("sel", {28'd0, WB_SEL_OUT}, {28'd0, cur.sel});
            chk("dat_wr", WB_DAT_WR_OUT, cur.wdat);
        end
        p_rst = RST_SYNC; p_en = EN; p_acc = e_ack;
        p_req = nxt;
        p_req.we = REQ_WE_IN; p_req.addr = REQ_ADDR_IN;
        p_req.sel = REQ_SEL_IN; p_req.wdat = REQ_WR_DATA_IN;
        // Slave for the coming edge; ACK/ERR noise where the controller must ignore it.
        WB_DAT_RD_IN = 32'($urandom());
        WB_STALL_IN  = 1'($urandom_range(0, 1));
        WB_ACK_IN    = 1'($urandom_range(0, 1));
        WB_ERR_IN    = 1'($urandom_range(0, 1));
        if (e_cyc) begin
            WB_STALL_IN = (rel <= cur.s);
            if (rel > cur.s + 1) begin
                WB_ACK_IN = 1'b0; WB_ERR_IN = 1'b0;
                if (rel == 2 + cur.s + cur.w) begin
                    WB_ACK_IN    = (cur.kind == K_ACK || cur.kind == K_BOTH);
                    WB_ERR_IN    = (cur.kind == K_ERR || cur.kind == K_BOTH);
                    WB_DAT_RD_IN = cur.rdat;
                end
            end
        end
    end

    task automatic offer(input txn_t t);
        int n;
        nxt = t;
        REQ_IN = 1'b1; REQ_WE_IN = t.we; REQ_ADDR_IN = t.addr;
        REQ_SEL_IN = t.sel; REQ_WR_DATA_IN = t.wdat; EN = 1'b1;
        #1;
        n = 0;
        while (!REQ_ACK_OUT && n < 50) begin @(posedge CLK); #1; n++; end
        chk1("accept_bound", n < 50, 1'b1);
        @(posedge CLK); #1;
        REQ_IN = 1'b0;
    endtask

    task automatic run_txn(input txn_t t, input int pause_at, input int pause_len,
                           output int lat, output int stb_n, output int cyc_n,
                           output logic err, output logic to);
        offer(t);
        lat = 1; stb_n = 0; cyc_n = 0;
        while (!RSP_VALID_OUT && lat < 100) begin
            stb_n += WB_STB_OUT ? 1 : 0;
            cyc_n += WB_CYC_OUT ? 1 : 0;
            EN = !(lat >= pause_at && lat < pause_at + pause_len);
            @(posedge CLK); #1;
            lat++;
        end
        EN = 1'b1;
        chk1("rsp_bound", lat < 100, 1'b1);
        err = RSP_ERR_OUT; to = RSP_TIMEOUT_OUT;
    endtask

    initial begin
        int lat, stb_n, cyc_n, n, r;
        logic err, to;
        txn_t t;
        RST_SYNC = 1'b1; EN = 1'b1; REQ_IN = 1'b0; REQ_WE_IN = 1'b0;
        REQ_ADDR_IN = '0; REQ_SEL_IN = '0; REQ_WR_DATA_IN = '0;
        nxt = mk(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, K_ACK, 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST_SYNC = 1'b0;
        chk1("reset_cyc", WB_CYC_OUT, 1'b0);
        chk1("reset_rsp_valid", RSP_VALID_OUT, 1'b0);
        chk("reset_rd_data", RSP_RD_DATA_OUT, 32'h0);
        chk("reset_adr", WB_ADR_OUT, 32'h0);
        @(posedge CLK); #1;

        run_txn(mk(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, K_ACK, 32'hDEADBEEF), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("rd_latency", lat, 3);
        chk("rd_stb_cycles", stb_n, 1);
        chk1("rd_err", err, 1'b0);
        chk("rd_value", RSP_RD_DATA_OUT, 32'hDEADBEEF);

        run_txn(mk(1'b1, 32'h104, 32'h12345678, 4'hF, 2, 0, K_ACK, 32'h0), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("wr_stb_cycles", stb_n, 3);
        chk("wr_latency", lat, 5);
        chk("wr_rd_unchanged", RSP_RD_DATA_OUT, 32'hDEADBEEF);

        run_txn(mk(1'b0, 32'h101, 32'h0, 4'hC, 0, 0, K_ACK, 32'h0), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("illegal_latency", lat, 1);
        chk("illegal_cyc", cyc_n, 0);
        chk1("illegal_err", err, 1'b1);
        run_txn(mk(1'b0, 32'h102, 32'h0, 4'h3, 0, 1, K_ACK, 32'hA5A50033), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("half_latency", lat, 4);
        chk1("half_err", err, 1'b0);
        chk("half_value", RSP_RD_DATA_OUT, 32'hA5A50033);

        run_txn(mk(1'b0, 32'h108, 32'h0, 4'hF, 0, 20, K_NONE, 32'h0), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("tmo_cyc_cycles", cyc_n, 8);
        chk1("tmo_err", err, 1'b1);
        chk1("tmo_flag", to, 1'b1);
        run_txn(mk(1'b0, 32'h10C, 32'h0, 4'hF, 1, 5, K_ACK, 32'h0BADF00D), 0, 0, lat, stb_n, cyc_n, err, to);
        chk("ack8_cyc_cycles", cyc_n, 8);
        chk1("ack8_err", err, 1'b0);
        chk1("ack8_flag", to, 1'b0);
        chk("ack8_value", RSP_RD_DATA_OUT, 32'h0BADF00D);

        run_txn(mk(1'b0, 32'h110, 32'h0, 4'hF, 0, 0, K_BOTH, 32'h11112222), 0, 0, lat, stb_n, cyc_n, err, to);
        chk1("both_err", err, 1'b1);
        chk("both_rd_unchanged", RSP_RD_DATA_OUT, 32'h0BADF00D);

        run_txn(mk(1'b0, 32'h114, 32'h0, 4'hF, 0, 6, K_ACK, 32'hCAFE0001), 1, 3, lat, stb_n, cyc_n, err, to);
        chk("en_latency", lat, 12);
        chk("en_stb_cycles", stb_n, 4);
        chk("en_cyc_cycles", cyc_n, 11);
        chk1("en_flag", to, 1'b0);
        chk("en_value", RSP_RD_DATA_OUT, 32'hCAFE0001);

        offer(mk(1'b0, 32'h200, 32'h0, 4'hF, 0, 10, K_ACK, 32'h77777777));
        @(posedge CLK); #1;
        chk1("pre_rst_cyc", WB_CYC_OUT, 1'b1);
        chk1("pre_rst_stb", WB_STB_OUT, 1'b0);
        RST_SYNC = 1'b1;
        @(posedge CLK); #1;
        RST_SYNC = 1'b0;
        chk1("rst_cyc", WB_CYC_OUT, 1'b0);
        chk("rst_rd_data", RSP_RD_DATA_OUT, 32'h0);
        chk("rst_adr", WB_ADR_OUT, 32'h0);
        n = 0;
        repeat (5) begin n += RSP_VALID_OUT ? 1 : 0; @(posedge CLK); #1; end
        chk("rst_no_rsp", n, 0);

        for (int i = 0; i < 3000; i++) begin
            RST_SYNC = ($urandom_range(0, 199) == 0);
            EN = RST_SYNC || ($urandom_range(0, 9) != 0);
            REQ_IN = 1'($urandom_range(0, 1));
            REQ_WE_IN = 1'($urandom_range(0, 1));
            REQ_ADDR_IN = 32'($urandom());
            if ($urandom_range(0, 1) == 0) REQ_ADDR_IN[1:0] = 2'b00;
            r = $urandom_range(0, 3);
            REQ_SEL_IN = (r == 0) ? 4'hF : (r == 1) ? 4'hC : (r == 2) ? 4'h3 : 4'($urandom());
            REQ_WR_DATA_IN = 32'($urandom());
            t = mk(1'b0, 32'h0, 32'h0, 4'h0, $urandom_range(0, 3), $urandom_range(0, 8), K_ACK, 32'($urandom()));
            r = $urandom_range(0, 9);
            t.kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
            nxt = t;
            @(posedge CLK); #1;
        end
        RST_SYNC = 1'b0; EN = 1'b1; REQ_IN = 1'b0;
        repeat (20) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
